// File: rtl/frame_reader_if.sv
// Wishbone classic/burst bus between frame_reader (master) and the SDRAM
// controller (slave).
interface frame_reader_if;
    logic        wshb_cyc;
    logic        wshb_stb;
    logic        wshb_we;
    logic [31:0] wshb_adr;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_dat_sm;
    logic        wshb_ack;
    logic        wshb_err;

    modport master (
        output wshb_cyc, wshb_stb, wshb_we, wshb_adr,
        output wshb_sel, wshb_cti, wshb_bte,
        input  wshb_dat_sm, wshb_ack, wshb_err
    );

    modport slave (
        input  wshb_cyc, wshb_stb, wshb_we, wshb_adr,
        input  wshb_sel, wshb_cti, wshb_bte,
        output wshb_dat_sm, wshb_ack, wshb_err
    );
endinterface

// File: rtl/frame_reader.sv
// Streams a frame from SDRAM over Wishbone into the video FIFO.
// Define FRAME_READER_BURST_EN for aligned 8-beat incrementing bursts.
module frame_reader #(
    parameter int unsigned HDISP    = 800,
    parameter int unsigned VDISP    = 480,
    parameter logic [31:0] BASE_ADR = 32'h0
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           enable,
    frame_reader_if.master wshb,
    output logic [31:0]    fifo_wdata,
    output logic           fifo_write,
    input  logic           fifo_wfull_almost,
    output logic           frame_end
);
    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IW-1:0] LAST = IW'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] index;
    logic [IW-1:0] index_nxt;
    logic          take;
    logic          last;
    logic          boundary;

    // err wins over a simultaneous ack
    assign take = (state == READ) && wshb.wshb_ack && !wshb.wshb_err;
    assign last = (index == LAST);

`ifdef FRAME_READER_BURST_EN
    assign boundary      = &index[2:0];
    assign wshb.wshb_cti = (state != READ) ? 3'b000 :
                           boundary        ? 3'b111 : 3'b010;
`else
    assign boundary      = 1'b1;
    assign wshb.wshb_cti = 3'b000;
`endif

    assign wshb.wshb_cyc = (state == READ);
    assign wshb.wshb_stb = (state == READ);
    assign wshb.wshb_we  = 1'b0;
    assign wshb.wshb_sel = 4'hF;
    assign wshb.wshb_bte = 2'b00;
    assign wshb.wshb_adr = BASE_ADR + (32'(index) << 2);

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        unique case (state)
            IDLE: begin
                if (enable && !fifo_wfull_almost) begin
                    state_nxt = READ;
                    index_nxt = '0;
                end
            end
            READ: begin
                if (wshb.wshb_err) begin
`ifdef FRAME_READER_BURST_EN
                    index_nxt = index & ~IW'(7);
`endif
                end else if (wshb.wshb_ack) begin
                    index_nxt = last ? '0 : index + 1'b1;
                    // stop/stall decisions only between bursts
                    if (boundary) begin
                        if (last && !enable) begin
                            state_nxt = IDLE;
                        end else if (fifo_wfull_almost) begin
                            state_nxt = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (!fifo_wfull_almost) begin
                    state_nxt = READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            index      <= '0;
            fifo_wdata <= '0;
            fifo_write <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            state      <= state_nxt;
            index      <= index_nxt;
            fifo_write <= take;
            frame_end  <= take && last;
            if (take) begin
                fifo_wdata <= wshb.wshb_dat_sm;
            end
        end
    end
endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: reactive Wishbone slave model plus a
// scoreboard of expected FIFO words (HDISP=8, VDISP=4, BASE_ADR=0x100).
module tb_frame_reader;
    localparam logic [31:0] BASE = 32'h100;
    localparam int NPIX = 32;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        afull = 1'b0;
    logic [31:0] fifo_wdata;
    logic        fifo_write;
    logic        frame_end;
    logic        err_arm = 1'b0;
    logic        err_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int writes = 0;
    int frames = 0;
    int k = 0;
    exp_t q[$];

    frame_reader_if bus ();

    frame_reader #(
        .HDISP(8),
        .VDISP(4),
        .BASE_ADR(BASE)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .enable(enable),
        .wshb(bus),
        .fifo_wdata(fifo_wdata),
        .fifo_write(fifo_write),
        .fifo_wfull_almost(afull),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pix(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            e.d = pix(BASE + 32'(4 * i));
            e.l = (i == NPIX - 1);
            q.push_back(e);
        end
    endtask

    // Slave: answers each request one cycle later; one err (with ack) at 0x110
    always @(posedge clk) begin
        if (rst) begin
            bus.wshb_ack    <= 1'b0;
            bus.wshb_err    <= 1'b0;
            bus.wshb_dat_sm <= '0;
        end else begin
            bus.wshb_ack <= 1'b0;
            bus.wshb_err <= 1'b0;
            if (bus.wshb_cyc && bus.wshb_stb &&
                !bus.wshb_ack && !bus.wshb_err) begin
                bus.wshb_ack <= 1'b1;
                if (err_arm && !err_done && bus.wshb_adr == 32'h110) begin
                    bus.wshb_err    <= 1'b1;
                    bus.wshb_dat_sm <= 32'hBAD0BAD0;
                    err_done        <= 1'b1;
                end else begin
                    bus.wshb_dat_sm <= pix(bus.wshb_adr);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic [2:0] ecti;
        if (rst) k = 0;
        if (fifo_write) begin
            writes++;
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("fifo_data", fifo_wdata, e.d);
                chk("frame_end", 32'(frame_end), 32'(e.l));
            end
            if (frame_end) frames++;
        end else if (frame_end) begin
            chk("frame_end_no_write", 32'(fifo_write), 32'd1);
        end
        if (!rst && bus.wshb_ack && !bus.wshb_err) begin
            chk("ack_adr", bus.wshb_adr, BASE + 32'(4 * k));
            k = (k + 1) % NPIX;
`ifdef FRAME_READER_BURST_EN
            ecti = (bus.wshb_adr[4:2] == 3'd7) ? 3'b111 : 3'b010;
`else
            ecti = 3'b000;
`endif
            chk("cti", 32'(bus.wshb_cti), 32'(ecti));
        end
    end

    initial begin
        int n;
        logic [31:0] resume;
`ifdef FRAME_READER_BURST_EN
        resume = 32'h120;
`else
        resume = 32'h118;
`endif
        repeat (3) tick();
        chk("rst_cyc", 32'(bus.wshb_cyc), 0);
        chk("rst_stb", 32'(bus.wshb_stb), 0);
        chk("rst_fifo_write", 32'(fifo_write), 0);
        chk("rst_frame_end", 32'(frame_end), 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_cti", 32'(bus.wshb_cti), 0);
        chk("rst_we", 32'(bus.wshb_we), 0);
        chk("rst_sel", 32'(bus.wshb_sel), 32'hF);
        chk("rst_bte", 32'(bus.wshb_bte), 0);
        chk("rst_adr", bus.wshb_adr, BASE);
        rst = 1'b0;
        tick();
        chk("idle_no_enable", 32'(bus.wshb_cyc), 0);

        // frames 1-3 back to back; err injected once in frame 1
        push_frame();
        push_frame();
        push_frame();
`ifndef FRAME_READER_BURST_EN
        err_arm = 1'b1;
`endif
        enable = 1'b1;
        for (int i = 0; i < 400 && frames < 1; i++) tick();
        chk("frame1_done", 32'(frames), 1);
        chk("frame1_writes", 32'(writes), 32);
        chk("wrap_no_idle", 32'(bus.wshb_cyc), 1);
        chk("wrap_adr", bus.wshb_adr, BASE);
`ifndef FRAME_READER_BURST_EN
        chk("err_issued", 32'(err_done), 1);
`endif

        // almost-full from word 5 of frame 2
        for (int i = 0; i < 100 &&
             !(bus.wshb_stb && bus.wshb_adr == 32'h114); i++) tick();
        chk("reach_0x114", bus.wshb_adr, 32'h114);
        afull = 1'b1;
        for (int i = 0; i < 20 && bus.wshb_stb; i++) tick();
        chk("hold_stb_low", 32'(bus.wshb_stb), 0);
        chk("hold_adr", bus.wshb_adr, resume);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.wshb_stb) n++;
        end
        chk("hold_stb_cycles", 32'(n), 0);
        afull = 1'b0;
        tick();
        tick();
        chk("resume_stb", 32'(bus.wshb_stb), 1);
        chk("resume_adr", bus.wshb_adr, resume);
        for (int i = 0; i < 400 && frames < 2; i++) tick();
        chk("frame2_writes", 32'(writes), 64);

        // enable dropped mid-frame 3
        for (int i = 0; i < 400 && writes < 76; i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 400 && frames < 3; i++) tick();
        chk("frame3_writes", 32'(writes), 96);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.wshb_cyc) n++;
        end
        chk("stopped_cyc", 32'(n), 0);
        chk("sb_drained", 32'(q.size()), 0);

        // restart, then reset with an ack pending at 0x140
        push_frame();
        enable = 1'b1;
        for (int i = 0; i < 20 && !bus.wshb_stb; i++) tick();
        chk("restart_adr", bus.wshb_adr, BASE);
        for (int i = 0; i < 200 &&
             !(bus.wshb_adr == 32'h140 && bus.wshb_ack); i++) tick();
        chk("reach_0x140_ack", 32'(bus.wshb_ack), 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_write", 32'(fifo_write), 0);
        chk("rst_mid_cyc", 32'(bus.wshb_cyc), 0);
        chk("rst_mid_stb", 32'(bus.wshb_stb), 0);
        chk("rst_mid_words", 32'(q.size()), 16);
        q.delete();
        push_frame();
        rst = 1'b0;
        for (int i = 0; i < 20 && !bus.wshb_stb; i++) tick();
        chk("post_rst_adr", bus.wshb_adr, BASE);
        enable = 1'b0;
        for (int i = 0; i < 400 && frames < 4; i++) tick();
        chk("frame5_writes", 32'(writes), 144);
        tick();
        tick();
        chk("final_idle", 32'(bus.wshb_cyc), 0);
        chk("final_sb", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
